// File: rtl/alpha_settle_detect.sv
// alpha_settle_detect
//   Watches the free-running alpha word from the bisection root finder and
//   declares convergence once SETTLE consecutive sample-to-sample changes
//   stay within TOL. The settled word is latched and offered on a
//   valid/ready handshake. If no settle happens within MAX_CYC comparisons,
//   the last sample is offered instead with timeout set.
//
// Ports
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   start        in   one-cycle arm / re-arm request
//   alpha_in     in   [W-1:0] unsigned alpha sample
//   result       out  [W-1:0] latched settled (or last) alpha
//   result_valid out  result available, held until accepted
//   result_ready in   consumer accept
//   busy         out  high while tracking
//   timeout      out  result came from timeout, not settling
//   iter_count   out  [CNT_W-1:0] comparisons consumed, frozen on exit

module alpha_settle_detect #(
    parameter int unsigned W       = 20,
    parameter int unsigned TOL     = 4,
    parameter int unsigned SETTLE  = 8,
    parameter int unsigned MAX_CYC = 1024,
    parameter int unsigned CNT_W   = 11
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [W-1:0]     alpha_in,
    output logic [W-1:0]     result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             busy,
    output logic             timeout,
    output logic [CNT_W-1:0] iter_count
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StTrack = 2'd1,
        StDone  = 2'd2
    } state_e;

    localparam logic [W:0]       TolW     = (W+1)'(TOL);
    localparam logic [7:0]       SettleM1 = 8'(SETTLE - 1);
    localparam logic [CNT_W-1:0] MaxM1    = CNT_W'(MAX_CYC - 1);

    state_e           r_state;
    logic [W-1:0]     r_prev;
    logic [7:0]       r_stable;
    logic [W-1:0]     r_result;
    logic             r_valid;
    logic             r_busy;
    logic             r_timeout;
    logic [CNT_W-1:0] r_iter;

    logic signed [W:0] w_diff_s;
    logic [W:0]        w_diff_abs;
    logic              w_in_tol;
    logic              w_settle;
    logic              w_expire;

    // Difference taken one bit wider so 0xFFFFF -> 0x00000 reads as a large
    // step rather than wrapping to 1.
    always_comb begin
        w_diff_s   = $signed({1'b0, alpha_in}) - $signed({1'b0, r_prev});
        w_diff_abs = w_diff_s[W] ? $unsigned(-w_diff_s) : $unsigned(w_diff_s);
        w_in_tol   = (w_diff_abs <= TolW);
        w_settle   = w_in_tol && (r_stable == SettleM1);
        w_expire   = (r_iter == MaxM1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= StIdle;
            r_prev    <= '0;
            r_stable  <= '0;
            r_result  <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_iter    <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_state   <= StTrack;
                        r_prev    <= alpha_in;
                        r_stable  <= '0;
                        r_iter    <= '0;
                        r_busy    <= 1'b1;
                        r_timeout <= 1'b0;
                    end
                end
                StTrack: begin
                    if (start) begin
                        // Re-arm: resample the reference, no comparison this edge.
                        r_prev    <= alpha_in;
                        r_stable  <= '0;
                        r_iter    <= '0;
                        r_busy    <= 1'b1;
                        r_timeout <= 1'b0;
                    end else begin
                        r_prev   <= alpha_in;
                        r_iter   <= r_iter + 1'b1;
                        r_stable <= w_in_tol ? r_stable + 1'b1 : 8'd0;
                        // Settle takes priority over an expiry on the same edge.
                        if (w_settle) begin
                            r_result  <= alpha_in;
                            r_valid   <= 1'b1;
                            r_busy    <= 1'b0;
                            r_timeout <= 1'b0;
                            r_state   <= StDone;
                        end else if (w_expire) begin
                            r_result  <= alpha_in;
                            r_valid   <= 1'b1;
                            r_busy    <= 1'b0;
                            r_timeout <= 1'b1;
                            r_state   <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (result_ready) begin
                        r_valid <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign result       = r_result;
    assign result_valid = r_valid;
    assign busy         = r_busy;
    assign timeout      = r_timeout;
    assign iter_count   = r_iter;

endmodule
